calc1_port_scheduler: RTL and testbench
=======================================

Name: calc1_port_scheduler

Overview:
Shares one calc1 request port (cmd/data in, resp/data out) between NUM_REQ local requesters.
- Each requester presents a complete operation (cmd, operand1, operand2) with a valid/ready handshake.
- The block arbitrates round-robin and serialises the winner onto calc1's two-cycle protocol: cycle 1 carries cmd + operand1, cycle 2 carries cmd=0 + operand2.
- It waits for calc1's non-zero response, then returns resp + data to the winning requester. One operation is outstanding at a time.
- It sits between the client logic and one of calc1's four ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, WAIT cycles without a response before the block reports a timeout.
- DATA_W, 32, operand/result width; must match calc1.

Ports:
- c_clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i = requester i has an operation pending.
- req_ready  out  NUM_REQ  one-hot; one-cycle pulse accepting requester i's operation.
- req_cmd  in  4*NUM_REQ  requester i cmd at bits [4i:4i+3].
- req_op1  in  DATA_W*NUM_REQ  requester i operand1 at slice i.
- req_op2  in  DATA_W*NUM_REQ  requester i operand2 at slice i.
- rsp_valid  out  NUM_REQ  one-hot; one-cycle pulse returning a result to requester i.
- rsp_code  out  2  1=success, 2=calc1 error (overflow/underflow/invalid), 3=timeout; 0 when rsp_valid is low.
- rsp_data  out  DATA_W  result; 0 unless rsp_code=1.
- calc_cmd_out  out  4  to calc1 reqN_cmd_in.
- calc_data_out  out  DATA_W  to calc1 reqN_data_in.
- calc_resp_in  in  2  from calc1 out_respN.
- calc_data_in  in  DATA_W  from calc1 out_dataN.
- busy  out  1  high in every state except IDLE.
- err_spurious  out  1  sticky; set if calc_resp_in != 0 outside WAIT. Cleared only by reset.

Behaviour:
Reset:
- All outputs drive 0; state = IDLE; RR pointer = 0; timeout counter = 0.
- Reset asserted in any state aborts the operation silently, with no rsp_valid.

State machine, with one-cycle transitions unless noted:
- IDLE: if any req_valid, grant the first set bit at or after the RR pointer, searching upward and wrapping. Pulse req_ready[g] this cycle and latch cmd/op1/op2/g.
  - If the latched cmd is in {1,2,5,6}, go to ISSUE1.
  - Otherwise go to RESP with code 2 and nothing sent to calc1.
- ISSUE1: calc_cmd_out = cmd; calc_data_out = op1. Go to ISSUE2.
- ISSUE2: calc_cmd_out = 0; calc_data_out = op2. Clear the counter. Go to WAIT.
- WAIT: calc_cmd_out = 0; calc_data_out = 0. Counter increments each cycle.
  - If calc_resp_in != 0, capture resp and data, then go to RESP. A response takes priority over a timeout in the same cycle.
  - Else if the counter reaches TIMEOUT_CYCLES-1, go to RESP with code 3 and data 0.
- RESP: pulse rsp_valid[g] with rsp_code/rsp_data. RR pointer = g+1 mod NUM_REQ. Go to IDLE.

Handshake and arbitration:
- Latency from acceptance to rsp_valid is 3 + (calc1 response delay) cycles. Minimum acceptance-to-acceptance spacing is 5 cycles.
- Requesters hold valid and operands stable until ready. req_valid dropping before grant is legal and withdraws the request.
- A requester deasserting valid while its operation is in flight has no effect.
- If the pointer's requester is not valid, the search wraps. No requester waits more than NUM_REQ grants.
- Operands pass through unmodified. The block performs no arithmetic and does not check data widths.
- A calc1 response arriving during ISSUE1/ISSUE2 is ignored and sets err_spurious.

Decomposition:
- Package calc1_sched_pkg holds:
  - cmd constants: CMD_NOP=0, ADD=1, SUB=2, SHL=5, SHR=6;
  - resp constants: RSP_NONE=0, OK=1, ERR=2, TIMEOUT=3;
  - the state enum {IDLE, ISSUE1, ISSUE2, WAIT, RESP};
  - a helper function cmd_is_valid.
- Sub-module calc1_rr_arbiter (NUM_REQ-wide round-robin): inputs request vector and pointer; output one-hot grant.

Test Plan:
1. Requester 0: ADD 0x1 + 0x1FFFFFF, real calc1 -> calc1 sees cmd 1/0x1 then 0/0x1FFFFFF; rsp_valid[0], code 1, data 0x2000000.
2. Requester 2: ADD 0xFFFFFFFF + 0x1 -> rsp_valid[2], code 2, data 0. Then SUB 0x1 - 0xF -> code 2.
3. All four valid with ADD 0+0 in the same cycle after reset -> grants in order 0,1,2,3, 5+ cycles apart. Re-assert after grant 1 -> the next grant order continues 2,3,0,…, never starving.
4. Requester 1 with cmd 3, then cmd 4 -> no activity on calc_cmd_out; rsp_valid[1], code 2, 2 cycles after req_ready.
5. Stubbed calc1 that never responds, TIMEOUT_CYCLES=8 -> code 3 exactly 8 WAIT cycles after ISSUE2. A subsequent request is accepted and completes normally.
6. reset pulsed during WAIT -> next cycle all outputs 0, busy 0, no rsp_valid. A late calc1 response then sets err_spurious=1.

Source files
------------

// File: rtl/calc1_sched_pkg.sv
// rtl/calc1_sched_pkg.sv - shared constants, state encoding and helpers for the calc1 port scheduler
package calc1_sched_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RSP_NONE    = 2'd0;
    localparam logic [1:0] RSP_OK      = 2'd1;
    localparam logic [1:0] RSP_ERR     = 2'd2;
    localparam logic [1:0] RSP_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE1 = 3'd1,
        ST_ISSUE2 = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } sched_state_t;

    // Only these commands are ever forwarded to calc1; anything else is rejected locally.
    function automatic logic cmd_is_valid(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
    endfunction

endpackage

// File: rtl/calc1_rr_arbiter.sv
// rtl/calc1_rr_arbiter.sv - round-robin one-hot grant starting at a pointer and wrapping upward
module calc1_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant
);

    logic w_found;

    // First pass covers ptr..top, second pass wraps to 0..ptr-1.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && i_req[j] && (j >= int'(i_ptr))) begin
                o_grant[j] = 1'b1;
                w_found    = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && i_req[j]) begin
                o_grant[j] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc1_port_scheduler.sv
// rtl/calc1_port_scheduler.sv - shares one calc1 port among NUM_REQ requesters, one operation at a time
module calc1_port_scheduler
    import calc1_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DATA_W         = 32
) (
    input  logic                      c_clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [4*NUM_REQ-1:0]      req_cmd,
    input  logic [DATA_W*NUM_REQ-1:0] req_op1,
    input  logic [DATA_W*NUM_REQ-1:0] req_op2,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [1:0]                rsp_code,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [3:0]                calc_cmd_out,
    output logic [DATA_W-1:0]         calc_data_out,
    input  logic [1:0]                calc_resp_in,
    input  logic [DATA_W-1:0]         calc_data_in,
    output logic                      busy,
    output logic                      err_spurious
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    sched_state_t        r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_gnt_idx;
    logic [3:0]          r_cmd;
    logic [DATA_W-1:0]   r_op1;
    logic [DATA_W-1:0]   r_op2;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_res_code;
    logic [DATA_W-1:0]   r_res_data;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [1:0]          r_rsp_code;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_err_spurious;

    logic [NUM_REQ-1:0]  w_grant;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic [3:0]          w_sel_cmd;
    logic [DATA_W-1:0]   w_sel_op1;
    logic [DATA_W-1:0]   w_sel_op2;
    logic                w_accept;

    calc1_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    always_comb begin
        w_gnt_idx = '0;
        w_sel_cmd = '0;
        w_sel_op1 = '0;
        w_sel_op2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_idx = PTR_W'(i);
                w_sel_cmd = req_cmd[4*i +: 4];
                w_sel_op1 = req_op1[DATA_W*i +: DATA_W];
                w_sel_op2 = req_op2[DATA_W*i +: DATA_W];
            end
        end
    end

    // Gated by reset so a request presented during reset is never acknowledged.
    assign w_accept  = (r_state == ST_IDLE) && !reset && (|req_valid);
    assign req_ready = w_accept ? w_grant : '0;

    always_comb begin
        calc_cmd_out  = '0;
        calc_data_out = '0;
        case (r_state)
            ST_ISSUE1: begin
                calc_cmd_out  = r_cmd;
                calc_data_out = r_op1;
            end
            ST_ISSUE2: begin
                calc_cmd_out  = CMD_NOP;
                calc_data_out = r_op2;
            end
            default: begin
                calc_cmd_out  = '0;
                calc_data_out = '0;
            end
        endcase
    end

    assign busy         = (r_state != ST_IDLE);
    assign rsp_valid    = r_rsp_valid;
    assign rsp_code     = r_rsp_code;
    assign rsp_data     = r_rsp_data;
    assign err_spurious = r_err_spurious;

    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_ptr          <= '0;
            r_gnt_idx      <= '0;
            r_cmd          <= '0;
            r_op1          <= '0;
            r_op2          <= '0;
            r_cnt          <= '0;
            r_res_code     <= RSP_NONE;
            r_res_data     <= '0;
            r_rsp_valid    <= '0;
            r_rsp_code     <= RSP_NONE;
            r_rsp_data     <= '0;
            r_err_spurious <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_code  <= RSP_NONE;
            r_rsp_data  <= '0;

            if ((calc_resp_in != RSP_NONE) && (r_state != ST_WAIT)) begin
                r_err_spurious <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_gnt_idx <= w_gnt_idx;
                        r_cmd     <= w_sel_cmd;
                        r_op1     <= w_sel_op1;
                        r_op2     <= w_sel_op2;
                        if (cmd_is_valid(w_sel_cmd)) begin
                            r_state <= ST_ISSUE1;
                        end else begin
                            r_res_code <= RSP_ERR;
                            r_res_data <= '0;
                            r_state    <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE1: begin
                    r_state <= ST_ISSUE2;
                end
                ST_ISSUE2: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A response beats a timeout landing in the same cycle.
                    if (calc_resp_in != RSP_NONE) begin
                        if (calc_resp_in == RSP_OK) begin
                            r_res_code <= RSP_OK;
                            r_res_data <= calc_data_in;
                        end else begin
                            r_res_code <= RSP_ERR;
                            r_res_data <= '0;
                        end
                        r_state <= ST_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_res_code <= RSP_TIMEOUT;
                        r_res_data <= '0;
                        r_state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_rsp_valid[r_gnt_idx] <= 1'b1;
                    r_rsp_code             <= r_res_code;
                    r_rsp_data             <= r_res_data;
                    r_ptr   <= (r_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_port_scheduler.sv
// tb/tb_calc1_port_scheduler.sv - scoreboard bench for calc1_port_scheduler with a small calc1 stub
module tb_calc1_port_scheduler;
    import calc1_sched_pkg::*;

    localparam int NUM_REQ        = 4;
    localparam int DATA_W         = 32;
    localparam int TIMEOUT_CYCLES = 8;

    logic                      c_clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [4*NUM_REQ-1:0]      req_cmd = '0;
    logic [DATA_W*NUM_REQ-1:0] req_op1 = '0;
    logic [DATA_W*NUM_REQ-1:0] req_op2 = '0;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [1:0]                rsp_code;
    logic [DATA_W-1:0]         rsp_data;
    logic [3:0]                calc_cmd_out;
    logic [DATA_W-1:0]         calc_data_out;
    logic [1:0]                calc_resp_in;
    logic [DATA_W-1:0]         calc_data_in;
    logic                      busy;
    logic                      err_spurious;

    logic [1:0]        stub_resp = '0;
    logic [DATA_W-1:0] stub_data = '0;
    logic [1:0]        man_resp  = '0;
    logic [DATA_W-1:0] man_data  = '0;
    assign calc_resp_in = stub_resp | man_resp;
    assign calc_data_in = stub_data | man_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          idx;
        logic [1:0]  code;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    int          stub_mode = 0;
    int          stub_stage = 0;
    int          stub_cnt = 0;
    logic [3:0]  s_cmd, seen_cmd1, seen_cmd2;
    logic [31:0] s_a, seen_op1, seen_op2;
    logic [1:0]  s_code;
    logic [31:0] s_res;

    calc1_port_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .DATA_W         (DATA_W)
    ) dut (
        .c_clk         (c_clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cmd       (req_cmd),
        .req_op1       (req_op1),
        .req_op2       (req_op2),
        .rsp_valid     (rsp_valid),
        .rsp_code      (rsp_code),
        .rsp_data      (rsp_data),
        .calc_cmd_out  (calc_cmd_out),
        .calc_data_out (calc_data_out),
        .calc_resp_in  (calc_resp_in),
        .calc_data_in  (calc_data_in),
        .busy          (busy),
        .err_spurious  (err_spurious)
    );

    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    function automatic void calc_model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                       output logic [1:0] code, output logic [31:0] res);
        logic [32:0] wide;
        code = RSP_OK;
        res  = '0;
        case (cmd)
            CMD_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                if (wide[32]) code = RSP_ERR;
                else res = wide[31:0];
            end
            CMD_SUB: begin
                if (b > a) code = RSP_ERR;
                else res = a - b;
            end
            CMD_SHL: res = a << b[4:0];
            CMD_SHR: res = a >> b[4:0];
            default: code = RSP_ERR;
        endcase
    endfunction

    // calc1 stand-in: responds one cycle after operand2 unless stub_mode says never.
    initial begin
        forever begin
            @(negedge c_clk);
            if (reset) begin
                stub_stage = 0;
                stub_resp  = '0;
                stub_data  = '0;
            end else begin
                case (stub_stage)
                    0: if (calc_cmd_out != 4'd0) begin
                        s_cmd      = calc_cmd_out;
                        s_a        = calc_data_out;
                        seen_cmd1  = calc_cmd_out;
                        seen_op1   = calc_data_out;
                        stub_stage = 1;
                    end
                    1: begin
                        seen_cmd2 = calc_cmd_out;
                        seen_op2  = calc_data_out;
                        calc_model(s_cmd, s_a, calc_data_out, s_code, s_res);
                        stub_cnt   = 1;
                        stub_stage = (stub_mode == 1) ? 0 : 2;
                    end
                    2: begin
                        stub_cnt = stub_cnt - 1;
                        if (stub_cnt == 0) begin
                            stub_resp  = s_code;
                            stub_data  = (s_code == RSP_OK) ? s_res : 32'hDEAD_BEEF;
                            stub_stage = 3;
                        end
                    end
                    default: begin
                        stub_resp  = '0;
                        stub_data  = '0;
                        stub_stage = 0;
                    end
                endcase
            end
        end
    end

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        man_resp  = '0;
        man_data  = '0;
        repeat (2) @(negedge c_clk);
        reset = 1'b0;
    endtask

    task automatic send(input int r, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        output int acc, output bit ok);
        exp_t e;
        req_cmd[4*r +: 4]             = cmd;
        req_op1[DATA_W*r +: DATA_W]   = a;
        req_op2[DATA_W*r +: DATA_W]   = b;
        req_valid[r]                  = 1'b1;
        ok  = 1'b0;
        acc = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if (req_ready[r]) begin
                ok    = 1'b1;
                acc   = cyc;
                e.idx = r;
                if (!cmd_is_valid(cmd)) begin
                    e.code = RSP_ERR;
                    e.data = '0;
                end else if (stub_mode == 1) begin
                    e.code = RSP_TIMEOUT;
                    e.data = '0;
                end else begin
                    calc_model(cmd, a, b, e.code, e.data);
                end
                sb_q.push_back(e);
            end
            @(negedge c_clk);
        end
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(output int idx, output logic [1:0] code, output logic [31:0] data,
                            output int at, output bit ok, output bit act);
        ok = 1'b0; act = 1'b0; idx = -1; code = '0; data = '0; at = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1;
            if (calc_cmd_out != 4'd0) act = 1'b1;
            if (rsp_valid != '0) begin
                ok   = 1'b1;
                at   = cyc;
                code = rsp_code;
                data = rsp_data;
                for (int k = 0; k < NUM_REQ; k++) if (rsp_valid[k]) idx = k;
            end
            @(negedge c_clk);
        end
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (sb_q.size() > 0);
        if (ok) e = sb_q.pop_front();
        else begin
            e.idx = -1; e.code = '0; e.data = '0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%h want=0", req_ready); end
        checks++; if (rsp_valid !== '0 || rsp_code !== 2'd0 || rsp_data !== '0) begin
            errors++; $display("FAIL reset_rsp got=%h/%0d/%h want=0/0/0", rsp_valid, rsp_code, rsp_data); end
        checks++; if (calc_cmd_out !== 4'd0 || calc_data_out !== '0) begin
            errors++; $display("FAIL reset_calc got=%h/%h want=0/0", calc_cmd_out, calc_data_out); end
        checks++; if (busy !== 1'b0 || err_spurious !== 1'b0) begin
            errors++; $display("FAIL reset_flags busy=%b spur=%b want=0/0", busy, err_spurious); end
        @(negedge c_clk);
    endtask

    task automatic run_one(input string name, input int r, input logic [3:0] cmd, input logic [31:0] a,
                           input logic [31:0] b, input int lat);
        int acc, at, idx; bit ok, rok, pok, act; logic [1:0] code; logic [31:0] data; exp_t e;
        send(r, cmd, a, b, acc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_accept ready never seen", name); end
        wait_rsp(idx, code, data, at, rok, act);
        checks++; if (!rok) begin errors++; $display("FAIL %s_rsp no rsp_valid within budget", name); end
        pop_exp(e, pok);
        checks++; if (!pok || idx != e.idx || code !== e.code || data !== e.data) begin
            errors++; $display("FAIL %s_result got=%0d/%0d/%h want=%0d/%0d/%h", name, idx, code, data, e.idx, e.code, e.data); end
        checks++; if (at - acc != lat) begin
            errors++; $display("FAIL %s_latency got=%0d want=%0d", name, at - acc, lat); end
    endtask

    task automatic test_add_ok();
        run_one("add_ok", 0, CMD_ADD, 32'h1, 32'h01FF_FFFF, 5);
        checks++; if (seen_cmd1 !== 4'd1 || seen_op1 !== 32'h1) begin
            errors++; $display("FAIL add_issue1 got=%h/%h want=1/00000001", seen_cmd1, seen_op1); end
        checks++; if (seen_cmd2 !== 4'd0 || seen_op2 !== 32'h01FF_FFFF) begin
            errors++; $display("FAIL add_issue2 got=%h/%h want=0/01ffffff", seen_cmd2, seen_op2); end
        checks++; if (s_res !== 32'h0200_0000 || s_code !== RSP_OK) begin
            errors++; $display("FAIL add_model got=%h want=02000000", s_res); end
    endtask

    task automatic test_calc_errors();
        run_one("add_ovf", 2, CMD_ADD, 32'hFFFF_FFFF, 32'h1, 5);
        run_one("sub_udf", 2, CMD_SUB, 32'h1, 32'hF, 5);
        run_one("shl_ok", 3, CMD_SHL, 32'h3, 32'h4, 5);
    endtask

    task automatic test_invalid_cmd();
        int acc, at, idx; bit ok, rok, pok, act; logic [1:0] code; logic [31:0] data; exp_t e;
        for (int c = 3; c <= 4; c++) begin
            send(1, 4'(c), 32'h1234, 32'h5678, acc, ok);
            wait_rsp(idx, code, data, at, rok, act);
            pop_exp(e, pok);
            checks++; if (!ok || !rok || !pok || idx != 1 || code !== RSP_ERR || data !== '0) begin
                errors++; $display("FAIL invalid_cmd%0d got=%0d/%0d/%h want=1/2/0", c, idx, code, data); end
            checks++; if (at - acc != 2) begin
                errors++; $display("FAIL invalid_cmd%0d_latency got=%0d want=2", c, at - acc); end
            checks++; if (act) begin
                errors++; $display("FAIL invalid_cmd%0d_calc_activity got=1 want=0", c); end
        end
    endtask

    task automatic test_round_robin();
        int exp_order[6];
        int ngrant, nresp, last_acc, g;
        exp_t e; bit pok;
        exp_order = '{0, 1, 2, 3, 0, 1};
        apply_reset();
        for (int r = 0; r < NUM_REQ; r++) begin
            req_cmd[4*r +: 4]           = CMD_ADD;
            req_op1[DATA_W*r +: DATA_W] = '0;
            req_op2[DATA_W*r +: DATA_W] = '0;
        end
        req_valid = '1;
        ngrant = 0; nresp = 0; last_acc = 0;
        for (int i = 0; i < 300 && (ngrant < 6 || nresp < 6); i++) begin
            #1;
            if (rsp_valid != '0) begin
                pop_exp(e, pok);
                checks++; if (!pok || rsp_valid !== NUM_REQ'(1 << e.idx) || rsp_code !== e.code || rsp_data !== e.data) begin
                    errors++; $display("FAIL rr_rsp%0d got=%b/%0d/%h want_idx=%0d code=%0d", nresp, rsp_valid, rsp_code, rsp_data, e.idx, e.code); end
                nresp++;
            end
            if (req_ready != '0 && ngrant < 6) begin
                g = 0;
                for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) g = k;
                checks++; if (!$onehot(req_ready) || g != exp_order[ngrant]) begin
                    errors++; $display("FAIL rr_grant%0d got=%b want_idx=%0d", ngrant, req_ready, exp_order[ngrant]); end
                if (ngrant > 0) begin
                    checks++; if (cyc - last_acc != 5) begin
                        errors++; $display("FAIL rr_spacing%0d got=%0d want=5", ngrant, cyc - last_acc); end
                end
                last_acc = cyc;
                e.idx = g; e.code = RSP_OK; e.data = '0;
                sb_q.push_back(e);
                ngrant++;
                @(negedge c_clk);
                req_valid[g] = 1'b0;
                if (ngrant == 2) begin
                    req_valid[0] = 1'b1;
                    req_valid[1] = 1'b1;
                end
            end else begin
                @(negedge c_clk);
            end
        end
        req_valid = '0;
        checks++; if (ngrant != 6 || nresp != 6) begin
            errors++; $display("FAIL rr_count grants=%0d rsps=%0d want=6/6", ngrant, nresp); end
    endtask

    task automatic test_timeout();
        stub_mode = 1;
        run_one("timeout", 3, CMD_ADD, 32'h5, 32'h6, 12);
        stub_mode = 0;
        run_one("after_timeout", 0, CMD_ADD, 32'h7, 32'h8, 5);
    endtask

    task automatic test_reset_abort();
        int acc; bit ok, pok, seen; exp_t e;
        stub_mode = 1;
        send(2, CMD_ADD, 32'h9, 32'hA, acc, ok);
        repeat (4) @(negedge c_clk);
        #1;
        checks++; if (!ok || busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b want=1", busy); end
        reset = 1'b1;
        @(negedge c_clk);
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== '0 || rsp_code !== 2'd0 || rsp_data !== '0
                      || calc_cmd_out !== 4'd0 || calc_data_out !== '0 || req_ready !== '0) begin
            errors++; $display("FAIL abort_outputs busy=%b rsp=%b code=%0d cmd=%h data=%h want all 0",
                               busy, rsp_valid, rsp_code, calc_cmd_out, calc_data_out); end
        pop_exp(e, pok);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge c_clk);
            #1;
            if (rsp_valid != '0) seen = 1'b1;
        end
        checks++; if (seen || err_spurious !== 1'b0) begin
            errors++; $display("FAIL abort_silent rsp_seen=%b spur=%b want=0/0", seen, err_spurious); end
        man_resp = RSP_OK;
        man_data = 32'h55;
        @(negedge c_clk);
        man_resp = '0;
        man_data = '0;
        #1;
        checks++; if (err_spurious !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL late_resp_spurious spur=%b busy=%b want=1/0", err_spurious, busy); end
        stub_mode = 0;
    endtask

    initial begin
        test_reset();
        test_add_ok();
        test_calc_errors();
        test_invalid_cmd();
        test_round_robin();
        test_timeout();
        test_reset_abort();
        checks++; if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
